// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder.
package scan_decoder_pkg;

   // Widest decoded output supported by the helpers below (SEL_W <= 8).
   localparam int unsigned MAX_N = 256;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Idle output pattern for an n-bit output: all zeros, or all ones when active-low.
   function automatic logic [MAX_N-1:0] inactive_pattern(int unsigned n, bit active_low);
      logic [MAX_N-1:0] ones;
      ones = {MAX_N{1'b1}};
      return active_low ? (ones >> (MAX_N - n)) : '0;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with selectable polarity.
module onehot_dec #(
   parameter int unsigned SEL_W      = 3,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic [SEL_W-1:0]      sel,
   output logic [(2**SEL_W)-1:0] dec
);

   // One hot bit at the selected position, inverted for active-low drivers.
   always_comb begin
      dec      = '0;
      dec[sel] = 1'b1;
      if (ACTIVE_LOW) begin
         dec = ~dec;
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with direct and auto-scan modes.
// Optional macro SCAN_DECODER_DEADTIME_EN: blank dec_out for one cycle whenever the
// scanned index changes, to suppress display ghosting.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned DIV_W      = 16,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel_in,
   input  logic                  sel_load,
   input  logic [DIV_W-1:0]      div,
   input  logic [SEL_W-1:0]      last_idx,
   output logic [(2**SEL_W)-1:0] dec_out,
   output logic [SEL_W-1:0]      cur_idx,
   output logic                  scan_wrap
);

   localparam int unsigned N = 2**SEL_W;
   localparam logic [N-1:0] INACTIVE = N'(inactive_pattern(N, ACTIVE_LOW));

   state_t           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             wrap_q, wrap_d;
   logic [N-1:0]     dec_q, dec_d;
   logic [N-1:0]     dec_next;

   // Next state depends only on the current en/mode inputs.
   always_comb begin
      state_d = ST_IDLE;
      if (en) begin
         state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
      end
   end

   // Index and prescaler update; load beats tick, entering SCAN restarts the prescaler.
   always_comb begin
      idx_d   = idx_q;
      presc_d = presc_q;
      wrap_d  = 1'b0;
      case (state_d)
         ST_DIRECT: begin
            idx_d   = sel_in;
            presc_d = '0;
         end
         ST_SCAN: begin
            if (sel_load) begin
               idx_d   = sel_in;
               presc_d = '0;
            end else if (state_q != ST_SCAN) begin
               presc_d = '0;
            end else if (presc_q == div) begin
               presc_d = '0;
               if (idx_q < last_idx) begin
                  idx_d = idx_q + 1'b1;
               end else begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   onehot_dec #(
      .SEL_W      (SEL_W),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_dec (
      .sel (idx_d),
      .dec (dec_next)
   );

`ifdef SCAN_DECODER_DEADTIME_EN
   logic blank_q, blank_d;

   // Blank on an index change unless the previous cycle was already blank, so a
   // new index is always shown for at least one cycle.
   always_comb begin
      blank_d = (state_d == ST_SCAN) && (idx_d != idx_q) && !blank_q;
      dec_d   = ((state_d == ST_IDLE) || blank_d) ? INACTIVE : dec_next;
   end

   // Dead-time history register.
   always_ff @(posedge clk) begin
      if (rst) begin
         blank_q <= 1'b0;
      end else begin
         blank_q <= blank_d;
      end
   end
`else
   // Output pattern follows the updated index directly.
   always_comb begin
      dec_d = (state_d == ST_IDLE) ? INACTIVE : dec_next;
   end
`endif

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         presc_q <= '0;
         wrap_q  <= 1'b0;
         dec_q   <= INACTIVE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         presc_q <= presc_d;
         wrap_q  <= wrap_d;
         dec_q   <= dec_d;
      end
   end

   assign dec_out   = dec_q;
   assign cur_idx   = idx_q;
   assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed tables and sequences plus random
// stimulus against a cycle-level reference model.
module tb_scan_decoder;

   logic        clk = 1'b0;
   logic        rst, en, mode, sel_load;
   logic [2:0]  sel_in, last_idx;
   logic [15:0] div;
   logic [7:0]  dec_out, dec_out_al;
   logic [2:0]  cur_idx, cur_idx_al;
   logic        scan_wrap, scan_wrap_al;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int         m_idx, m_presc;
   bit         m_wrap, m_in_scan, m_blank;
   logic [7:0] m_dec, m_dec_al;

   typedef struct {
      logic [2:0] sel;
      logic [7:0] dec;
   } dvec_t;
   dvec_t tbl[8];

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
      .div(div), .last_idx(last_idx), .dec_out(dec_out), .cur_idx(cur_idx),
      .scan_wrap(scan_wrap)
   );

   scan_decoder #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
      .div(div), .last_idx(last_idx), .dec_out(dec_out_al), .cur_idx(cur_idx_al),
      .scan_wrap(scan_wrap_al)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model one clock edge from the rules: reset, idle, direct, scan.
   task automatic model_step();
      int  old;
      bit  b;
      if (rst) begin
         m_idx = 0; m_presc = 0; m_wrap = 0; m_in_scan = 0; m_blank = 0; m_dec = 8'h00;
      end else if (!en) begin
         m_wrap = 0; m_in_scan = 0; m_blank = 0; m_dec = 8'h00;
      end else if (!mode) begin
         m_idx = sel_in; m_presc = 0; m_wrap = 0; m_in_scan = 0; m_blank = 0;
         m_dec = 8'(1 << m_idx);
      end else begin
         old    = m_idx;
         m_wrap = 0;
         if (sel_load) begin
            m_idx = sel_in; m_presc = 0;
         end else if (!m_in_scan) begin
            m_presc = 0;
         end else if (m_presc == int'(div)) begin
            m_presc = 0;
            if (m_idx < int'(last_idx)) m_idx = m_idx + 1;
            else begin m_idx = 0; m_wrap = 1; end
         end else begin
            m_presc = (m_presc + 1) % 65536;
         end
         m_in_scan = 1;
`ifdef SCAN_DECODER_DEADTIME_EN
         b = (m_idx != old) && !m_blank;
`else
         b = 0;
`endif
         m_blank = b;
         m_dec   = b ? 8'h00 : 8'(1 << m_idx);
      end
      m_dec_al = ~m_dec;
   endtask

   // One clock: update model at the edge, compare both DUTs just after it.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("dec_out", 32'(dec_out), 32'(m_dec));
      chk("dec_out_al", 32'(dec_out_al), 32'(m_dec_al));
      chk("cur_idx", 32'(cur_idx), 32'(m_idx));
      chk("scan_wrap", 32'(scan_wrap), 32'(m_wrap));
      chk("cur_idx_al", 32'(cur_idx_al), 32'(m_idx));
   endtask

   initial begin
      int zeros;
      int exp_seq[6];
      rst = 1; en = 0; mode = 0; sel_in = 0; sel_load = 0; div = 0; last_idx = 7;
      cyc(); cyc();
      rst = 0;

      // Reset aborts a scan in progress.
      en = 1; mode = 1; div = 0; last_idx = 7;
      repeat (5) cyc();
      rst = 1;
      cyc();
      chk("reset_dec", 32'(dec_out), 32'h00);
      chk("reset_dec_al", 32'(dec_out_al), 32'hFF);
      chk("reset_idx", 32'(cur_idx), 32'h0);
      chk("reset_wrap", 32'(scan_wrap), 32'h0);
      rst = 0;

      // Direct decode sweep.
      tbl[0] = '{3'd0, 8'h01}; tbl[1] = '{3'd1, 8'h02}; tbl[2] = '{3'd2, 8'h04};
      tbl[3] = '{3'd3, 8'h08}; tbl[4] = '{3'd4, 8'h10}; tbl[5] = '{3'd5, 8'h20};
      tbl[6] = '{3'd6, 8'h40}; tbl[7] = '{3'd7, 8'h80};
      mode = 0;
      for (int i = 0; i < 8; i++) begin
         sel_in = tbl[i].sel;
         cyc();
         chk("direct_dec", 32'(dec_out), 32'(tbl[i].dec));
         chk("direct_idx", 32'(cur_idx), 32'(tbl[i].sel));
      end

      // Scan with wrap: div=2, last_idx=5.
      mode = 1; div = 2; last_idx = 5; sel_load = 1; sel_in = 0;
      cyc();
      sel_load = 0;
      exp_seq = '{1, 2, 3, 4, 5, 0};
      for (int k = 0; k < 6; k++) begin
         cyc(); cyc();
         chk("scan_hold_idx", 32'(cur_idx), 32'((exp_seq[k] + 5) % 6));
         cyc();
         chk("scan_step_idx", 32'(cur_idx), 32'(exp_seq[k]));
         chk("scan_step_wrap", 32'(scan_wrap), 32'(k == 5));
         chk("scan_step_dec", 32'(dec_out), 32'(8'h01 << exp_seq[k]));
      end

      // Load priority over a tick at idx 5.
      repeat (15) cyc();
      chk("pre_load_idx", 32'(cur_idx), 32'd5);
      cyc(); cyc();
      sel_load = 1; sel_in = 3;
      cyc();
      chk("load_idx", 32'(cur_idx), 32'd3);
      chk("load_wrap", 32'(scan_wrap), 32'd0);
      sel_load = 0;
      cyc(); cyc();
      chk("load_hold", 32'(cur_idx), 32'd3);
      cyc();
      chk("load_next", 32'(cur_idx), 32'd4);

      // Shrunk range, then idle hold and resume.
      last_idx = 7; sel_load = 1; sel_in = 6;
      cyc();
      sel_load = 0; last_idx = 2;
      cyc(); cyc(); cyc();
      chk("shrink_idx", 32'(cur_idx), 32'd0);
      chk("shrink_wrap", 32'(scan_wrap), 32'd1);
      cyc(); cyc(); cyc();
      chk("pre_idle_idx", 32'(cur_idx), 32'd1);
      en = 0;
      repeat (4) cyc();
      chk("idle_dec", 32'(dec_out), 32'h00);
      chk("idle_dec_al", 32'(dec_out_al), 32'hFF);
      chk("idle_idx", 32'(cur_idx), 32'd1);
      en = 1;
      cyc();
      chk("resume_dec", 32'(dec_out), 32'h02);
      cyc(); cyc(); cyc();
      chk("resume_idx", 32'(cur_idx), 32'd2);

      // Fastest scan: dead-time blanking shows up only when the macro is set.
      div = 0; last_idx = 7; sel_load = 1; sel_in = 0;
      cyc();
      sel_load = 0;
      zeros = 0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         chk("fast_idx", 32'(cur_idx), 32'((k + 1) % 8));
         if (dec_out == 8'h00) zeros++;
      end
`ifdef SCAN_DECODER_DEADTIME_EN
      chk("fast_blank_count", 32'(zeros), 32'd8);
`else
      chk("fast_blank_count", 32'(zeros), 32'd0);
`endif

      // Random stimulus against the model.
      for (int k = 0; k < 3000; k++) begin
         rst      = ($urandom_range(0, 99) == 0);
         en       = ($urandom_range(0, 7) != 0);
         mode     = ($urandom_range(0, 3) != 0);
         sel_load = ($urandom_range(0, 9) == 0);
         sel_in   = 3'($urandom);
         if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) last_idx = 3'($urandom);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
